// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic pipeline stage register with valid/ready handshake,
// a 2-entry (main + skid) buffer, flush and bubble insertion.
// in_ready depends only on registered state, so there is no combinational
// path from out_ready to in_ready.
// Optional macro PIPE_STAGE_STATS_EN adds stall_cnt / bubble_cnt outputs.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
`ifdef PIPE_STAGE_STATS_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt,
`endif
  output logic [1:0]        occupancy
);

  logic              mainV;
  logic              skidV;
  logic [CTRL_W-1:0] mainCtrl;
  logic [DATA_W-1:0] mainData;
  logic [CTRL_W-1:0] skidCtrl;
  logic [DATA_W-1:0] skidData;
  logic              accept;
  logic              consume;

  // Handshake qualifiers and registered-state outputs.
  always_comb begin
    in_ready  = ~skidV;
    accept    = in_valid & ~skidV;
    consume   = mainV & out_ready;
    out_valid = mainV;
    out_ctrl  = mainV ? mainCtrl : '0;
    out_data  = mainData;
    occupancy = {1'b0, mainV} + {1'b0, skidV};
  end

  // Main/skid storage update: reset, then flush, then FIFO traffic.
  always_ff @(posedge clk) begin
    if (rst) begin
      mainV    <= 1'b0;
      skidV    <= 1'b0;
      mainCtrl <= '0;
      mainData <= '0;
      skidCtrl <= '0;
      skidData <= '0;
    end else if (flush) begin
      // A simultaneous consume already happened downstream; nothing to undo.
      mainV    <= 1'b0;
      skidV    <= 1'b0;
      mainCtrl <= '0;
    end else if (!mainV) begin
      // Skid is always empty here, since skid full implies main full.
      if (accept) begin
        mainV    <= 1'b1;
        mainCtrl <= in_ctrl;
        mainData <= in_data;
      end
    end else if (consume) begin
      if (skidV) begin
        mainCtrl <= skidCtrl;
        mainData <= skidData;
        skidV    <= 1'b0;
      end else if (accept) begin
        mainCtrl <= in_ctrl;
        mainData <= in_data;
      end else begin
        mainV    <= 1'b0;
        mainCtrl <= '0;
      end
    end else if (!skidV && accept) begin
      skidV    <= 1'b1;
      skidCtrl <= in_ctrl;
      skidData <= in_data;
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  logic [31:0] stallCnt;
  logic [31:0] bubbleCnt;

  // Stall and bubble counters; wrap naturally, cleared by reset only.
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt  <= '0;
      bubbleCnt <= '0;
    end else begin
      if (mainV && !out_ready) stallCnt <= stallCnt + 32'd1;
      if (!mainV) bubbleCnt <= bubbleCnt + 32'd1;
    end
  end

  assign stall_cnt  = stallCnt;
  assign bubble_cnt = bubbleCnt;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus a random
// traffic phase, with a scoreboard queue of accepted entries.
module tb_pipe_stage_reg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 16;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
`ifdef PIPE_STAGE_STATS_EN
  logic [31:0]       stall_cnt;
  logic [31:0]       bubble_cnt;
`endif

  int unsigned checkCnt = 0;
  int unsigned passCnt  = 0;
  entry_t      sbQ[$];

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data),
`ifdef PIPE_STAGE_STATS_EN
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
`endif
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCnt++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    else passCnt++;
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  // Scoreboard: the queue holds exactly the entries the stage should hold.
  always @(negedge clk) begin
    if (rst) begin
      sbQ.delete();
    end else begin
      checkVal("occ", 64'(occupancy), 64'(sbQ.size()));
      checkVal("inReady", 64'(in_ready), 64'(sbQ.size() < 2));
      if (!out_valid) checkVal("bubbleCtrl", 64'(out_ctrl), 64'd0);
      if (out_valid && out_ready) begin
        if (sbQ.size() == 0) begin
          checkVal("sbExtra", 64'(out_valid), 64'd0);
        end else begin
          entry_t e;
          e = sbQ.pop_front();
          checkVal("sbData", 64'(out_data), 64'(e.data));
          checkVal("sbCtrl", 64'(out_ctrl), 64'(e.ctrl));
        end
      end
      if (flush) sbQ.delete();
      else if (in_valid && in_ready) sbQ.push_back({in_ctrl, in_data});
    end
  end

  initial begin
    logic pending;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 16'hFFFF, 32'hDEAD_BEEF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkVal("rstValid", 64'(out_valid), 64'd0);
    checkVal("rstCtrl",  64'(out_ctrl), 64'd0);
    checkVal("rstData",  64'(out_data), 64'd0);
    checkVal("rstReady", 64'(in_ready), 64'd1);
    checkVal("rstOcc",   64'(occupancy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, '0, '0);

    // Full-rate stream.
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(1'b1, 16'h0001, 32'h11);
    @(posedge clk); #1;
    drive(1'b1, 16'h0002, 32'h22);
    @(negedge clk);
    checkVal("stream11", 64'(out_data), 64'h11);
    checkVal("streamRdy", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    drive(1'b1, 16'h0003, 32'h33);
    @(negedge clk);
    checkVal("stream22", 64'(out_data), 64'h22);
    @(posedge clk); #1;
    drive(1'b0, '0, '0);
    @(negedge clk);
    checkVal("stream33", 64'(out_data), 64'h33);
    checkVal("streamV", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    checkVal("streamEnd", 64'(out_valid), 64'd0);

    // Fill main and skid, then drain.
    out_ready = 1'b0;
    drive(1'b1, 16'h000A, 32'hA);
    @(posedge clk); #1;
    drive(1'b1, 16'h000B, 32'hB);
    @(posedge clk); #1;
    drive(1'b0, '0, '0);
    @(negedge clk);
    checkVal("skidOcc", 64'(occupancy), 64'd2);
    checkVal("skidRdy", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    checkVal("skidHold", 64'(out_data), 64'hA);
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkVal("skidB", 64'(out_data), 64'hB);
    checkVal("skidRdy1", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    checkVal("skidEmpty", 64'(out_valid), 64'd0);

    // Flush while full, with a competing input.
    out_ready = 1'b0;
    drive(1'b1, 16'h00C1, 32'hC1);
    @(posedge clk); #1;
    drive(1'b1, 16'h00C2, 32'hC2);
    @(posedge clk); #1;
    drive(1'b1, 16'h000C, 32'hC);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    drive(1'b0, '0, '0);
    @(negedge clk);
    checkVal("flushOcc",  64'(occupancy), 64'd0);
    checkVal("flushV",    64'(out_valid), 64'd0);
    checkVal("flushCtrl", 64'(out_ctrl), 64'd0);
    checkVal("flushRdy",  64'(in_ready), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkVal("flushNoC", 64'(out_valid), 64'd0);
    end

    // Flush overriding an accept that would otherwise happen.
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(1'b1, 16'h00D1, 32'hD1);
    @(posedge clk); #1;
    drive(1'b1, 16'h00D2, 32'hD2);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    drive(1'b0, '0, '0);
    @(negedge clk);
    checkVal("flush1Occ", 64'(occupancy), 64'd0);
    checkVal("flush1V", 64'(out_valid), 64'd0);

    // Bubble after a single all-ones control entry.
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive(1'b1, 16'hFFFF, 32'h5555);
    @(posedge clk); #1;
    drive(1'b0, '0, '0);
    @(negedge clk);
    checkVal("ctrlOnes", 64'(out_ctrl), 64'hFFFF);
    @(posedge clk); #1;
    @(negedge clk);
    checkVal("bubbleV", 64'(out_valid), 64'd0);
    checkVal("bubbleC", 64'(out_ctrl), 64'd0);
    checkVal("dataKeep", 64'(out_data), 64'h5555);

    // Random traffic; payload held stable while stalled.
    pending = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 40) == 0);
      if (!pending)
        drive($urandom_range(0, 3) != 0, CTRL_W'($urandom), DATA_W'($urandom));
      @(negedge clk);
      pending = in_valid && !in_ready && !flush;
    end

    // Drain remaining entries.
    @(posedge clk); #1;
    flush = 1'b0;
    drive(1'b0, '0, '0);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkVal("drainOcc", 64'(occupancy), 64'd0);
    checkVal("drainSb", 64'(sbQ.size()), 64'd0);

`ifdef PIPE_STAGE_STATS_EN
    begin
      logic [31:0] s0;
      @(posedge clk); #1;
      rst = 1'b1;
      out_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checkVal("bubbleRst", 64'(bubble_cnt), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      checkVal("bubble3", 64'(bubble_cnt), 64'd3);
      drive(1'b1, 16'h0077, 32'h77);
      @(posedge clk); #1;
      drive(1'b0, '0, '0);
      s0 = stall_cnt;
      repeat (5) @(posedge clk);
      #1;
      checkVal("stall5", 64'(stall_cnt - s0), 64'd5);
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
    end
`endif

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
